// File: rtl/multicycle_control_unit.sv
// Multi-cycle fetch/decode/execute/writeback sequencer in front of the 8-entry register file.
// Define RETIRE_CNT_EN to add the 32-bit retired-instruction counter output.
module multicycle_control_unit #(
    parameter int W   = 32,
    parameter int PCW = 8
) (
    input  logic           clock,
    input  logic           reset,
    output logic           imem_req,
    output logic [PCW-1:0] imem_addr,
    input  logic           imem_ack,
    input  logic [15:0]    imem_data,
    output logic [2:0]     rs1,
    output logic [2:0]     rs2,
    output logic [2:0]     rs3,
    output logic           we,
    output logic           is_branch,
    output logic [2:0]     alu_op,
    output logic           imm_sel,
    output logic [W-1:0]   imm_out,
    output logic [W-1:0]   pc_out,
    output logic           halted
`ifdef RETIRE_CNT_EN
    ,
    output logic [31:0]    retired
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'd5;
    localparam logic [3:0] OP_BR   = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;

    state_t         r_state;
    logic [PCW-1:0] r_pc;
    logic [15:0]    r_ir;

    logic [3:0]     w_op;
    logic [2:0]     w_rd;
    logic           w_alu_class;
    logic           w_in_wb;

    // Branch offset is relative to the already-incremented pc, wrapping mod 2^PCW.
    function automatic logic [PCW-1:0] branch_target(input logic [PCW-1:0] pc,
                                                     input logic [5:0]     imm6);
        logic signed [31:0] off;
        off = 32'(signed'(imm6));
        return pc + off[PCW-1:0];
    endfunction

    assign w_op        = r_ir[15:12];
    assign w_rd        = r_ir[11:9];
    assign w_alu_class = (w_op <= OP_LDI);
    assign w_in_wb     = (r_state == S_WB);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ack) begin
                        r_ir    <= imem_data;
                        r_pc    <= r_pc + PCW'(1);
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_op == OP_HALT) begin
                        r_state <= S_HALT;
                    end else if (w_op[3]) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: r_state <= S_WB;
                S_WB: begin
                    if (w_op == OP_BR) begin
                        r_pc <= branch_target(r_pc, r_ir[5:0]);
                    end
                    r_state <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Every output is a pure decode of the state and instruction registers.
    assign imem_req  = (r_state == S_FETCH);
    assign imem_addr = r_pc;
    assign rs1       = r_ir[8:6];
    assign rs2       = r_ir[5:3];
    assign rs3       = w_rd;
    assign we        = w_in_wb && w_alu_class && (w_rd != 3'd7);
    assign is_branch = w_in_wb && (w_op == OP_BR);
    assign alu_op    = w_alu_class ? w_op[2:0] : 3'd0;
    assign imm_sel   = (w_op == OP_LDI);
    assign imm_out   = W'(r_ir[5:0]);
    assign pc_out    = W'(r_pc);
    assign halted    = (r_state == S_HALT);

`ifdef RETIRE_CNT_EN
    logic [31:0] r_retired;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_retired <= '0;
        end else if (w_in_wb) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign retired = r_retired;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: expected writeback events are queued at fetch time.
module tb_multicycle_control_unit;

    localparam int W   = 32;
    localparam int PCW = 8;

    logic           clock;
    logic           reset;
    logic           imem_req;
    logic [PCW-1:0] imem_addr;
    logic           imem_ack;
    logic [15:0]    imem_data;
    logic [2:0]     rs1, rs2, rs3;
    logic           we, is_branch;
    logic [2:0]     alu_op;
    logic           imm_sel;
    logic [W-1:0]   imm_out, pc_out;
    logic           halted;
`ifdef RETIRE_CNT_EN
    logic [31:0]    retired;
`endif

    multicycle_control_unit #(.W(W), .PCW(PCW)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .rs1(rs1), .rs2(rs2), .rs3(rs3),
        .we(we), .is_branch(is_branch),
        .alu_op(alu_op), .imm_sel(imm_sel),
        .imm_out(imm_out), .pc_out(pc_out),
        .halted(halted)
`ifdef RETIRE_CNT_EN
        , .retired(retired)
`endif
    );

    typedef struct packed {
        logic        we;
        logic        br;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [2:0]  rs3;
        logic [2:0]  alu;
        logic        isel;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    exp_t           exp_q[$];
    exp_t           mon_e;
    exp_t           mon_a;
    logic [PCW-1:0] m_pc;
    int             checks = 0;
    int             errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every we/is_branch strobe must match the oldest queued expectation.
    always @(negedge clock) begin
        if (we === 1'b1 && is_branch === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL we_and_branch: both strobes high at pc_out=%0d", pc_out);
        end
        if (we === 1'b1 || is_branch === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: we=%0b is_branch=%0b rs3=%0d, none expected",
                         we, is_branch, rs3);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a.we   = we;
                mon_a.br   = is_branch;
                mon_a.rs1  = rs1;
                mon_a.rs2  = rs2;
                mon_a.rs3  = rs3;
                mon_a.alu  = is_branch ? 3'd0 : alu_op;
                mon_a.isel = is_branch ? 1'b0 : imm_sel;
                mon_a.imm  = imm_out;
                mon_a.pc   = pc_out;
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL wb_event: got %h want %h", mon_a, mon_e);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_pc = '0;
        exp_q.delete();
    endtask

    task automatic wait_fetch;
        int n = 0;
        while (imem_req !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL wait_fetch: imem_req=%0b after %0d cycles, want 1", imem_req, n);
        end
    endtask

    // Drives one fetch (DUT must be in FETCH) and queues the writeback it should cause.
    task automatic issue(input logic [15:0] instr, input int waits, input bit expect_wb);
        logic [3:0]     op;
        logic [PCW-1:0] nxt;
        exp_t           e;
        op  = instr[15:12];
        nxt = m_pc + 8'd1;
        if (expect_wb && op <= 4'd6 && !(op <= 4'd5 && instr[11:9] == 3'd7)) begin
            e.we   = (op <= 4'd5);
            e.br   = (op == 4'd6);
            e.rs1  = instr[8:6];
            e.rs2  = instr[5:3];
            e.rs3  = instr[11:9];
            e.alu  = (op <= 4'd5) ? op[2:0] : 3'd0;
            e.isel = (op == 4'd5);
            e.imm  = {26'd0, instr[5:0]};
            e.pc   = {24'd0, nxt};
            exp_q.push_back(e);
        end
        for (int i = 0; i < waits; i++) tick();
        imem_ack  = 1'b1;
        imem_data = instr;
        tick();
        imem_ack  = 1'b0;
        imem_data = 16'($urandom);
        m_pc = nxt;
        if (expect_wb && op == 4'd6) m_pc = nxt + {{2{instr[5]}}, instr[5:0]};
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 8'd0}) begin
            errors++;
            $display("FAIL reset_req_addr: got req=%0b addr=%0d want req=1 addr=0", imem_req, imem_addr);
        end
        checks++;
        if ({we, is_branch, halted, imm_sel} !== 4'b0) begin
            errors++;
            $display("FAIL reset_strobes: got we/br/halt/isel=%b want 0000", {we, is_branch, halted, imm_sel});
        end
        checks++;
        if ({rs1, rs2, rs3, alu_op} !== 12'd0 || imm_out !== '0 || pc_out !== '0) begin
            errors++;
            $display("FAIL reset_fields: got rs=%0d/%0d/%0d alu=%0d imm=%0d pc=%0d want all 0",
                     rs1, rs2, rs3, alu_op, imm_out, pc_out);
        end
    endtask

    task automatic test_add;
        wait_fetch();
        issue(16'h0250, 0, 1'b1);
        checks++;
        if ({imem_req, rs1, rs2, rs3, we} !== {1'b0, 3'd1, 3'd2, 3'd1, 1'b0} || pc_out !== 32'd1) begin
            errors++;
            $display("FAIL add_decode: got req=%0b rs=%0d/%0d/%0d we=%0b pc=%0d want 0 1/2/1 0 1",
                     imem_req, rs1, rs2, rs3, we, pc_out);
        end
        tick();
        checks++;
        if (we !== 1'b0) begin errors++; $display("FAIL add_exec_we: got %0b want 0", we); end
        tick();
        checks++;
        if (we !== 1'b1) begin errors++; $display("FAIL add_cycle4_we: got %0b want 1", we); end
        tick();
        checks++;
        if ({we, imem_req, imem_addr} !== {1'b0, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL add_refetch: got we=%0b req=%0b addr=%0d want 0 1 1", we, imem_req, imem_addr);
        end
    endtask

    task automatic test_wait;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({imem_req, imem_addr, we} !== {1'b1, 8'd1, 1'b0}) begin
                errors++;
                $display("FAIL wait_hold_%0d: got req=%0b addr=%0d we=%0b want 1 1 0",
                         i, imem_req, imem_addr, we);
            end
        end
        issue(16'h1250, 0, 1'b1);
        tick();
        tick();
        checks++;
        if ({we, alu_op} !== {1'b1, 3'd1}) begin
            errors++;
            $display("FAIL wait_wb: got we=%0b alu=%0d want 1 1", we, alu_op);
        end
    endtask

    task automatic test_branch;
        wait_fetch();
        issue(16'h2250, 0, 1'b1);
        wait_fetch();
        issue(16'h3250, 0, 1'b1);
        wait_fetch();
        checks++;
        if (imem_addr !== 8'd4) begin errors++; $display("FAIL br_start_pc: got %0d want 4", imem_addr); end
        issue(16'h603E, 0, 1'b1);
        tick();
        tick();
        checks++;
        if ({is_branch, we} !== 2'b10 || pc_out !== 32'd5) begin
            errors++;
            $display("FAIL br_wb: got br=%0b we=%0b pc=%0d want 1 0 5", is_branch, we, pc_out);
        end
        tick();
        checks++;
        if ({is_branch, imem_addr} !== {1'b0, 8'd3} || pc_out !== 32'd3) begin
            errors++;
            $display("FAIL br_target: got br=%0b addr=%0d pc=%0d want 0 3 3", is_branch, imem_addr, pc_out);
        end
    endtask

    task automatic test_ldi_r7;
        wait_fetch();
        issue(16'h562A, 0, 1'b1);
        checks++;
        if ({imm_sel, alu_op, rs3} !== {1'b1, 3'd5, 3'd3} || imm_out !== 32'd42) begin
            errors++;
            $display("FAIL ldi_decode: got isel=%0b alu=%0d rs3=%0d imm=%0d want 1 5 3 42",
                     imm_sel, alu_op, rs3, imm_out);
        end
        tick();
        tick();
        checks++;
        if (we !== 1'b1) begin errors++; $display("FAIL ldi_we: got %0b want 1", we); end
        wait_fetch();
        issue(16'h0E50, 0, 1'b1);
        tick();
        tick();
        checks++;
        if ({we, is_branch} !== 2'b00) begin
            errors++;
            $display("FAIL r7_nop: got we=%0b br=%0b want 0 0", we, is_branch);
        end
        wait_fetch();
    endtask

    task automatic test_illegal;
        issue(16'h9000, 0, 1'b1);
        checks++;
        if ({we, imem_req} !== 2'b00) begin
            errors++;
            $display("FAIL illegal_decode: got we=%0b req=%0b want 0 0", we, imem_req);
        end
        tick();
        checks++;
        if ({imem_req, imem_addr, we} !== {1'b1, m_pc, 1'b0}) begin
            errors++;
            $display("FAIL illegal_refetch: got req=%0b addr=%0d we=%0b want 1 %0d 0",
                     imem_req, imem_addr, we, m_pc);
        end
    endtask

    task automatic test_ignore_ack;
        wait_fetch();
        issue(16'h0A88, 0, 1'b1);
        imem_ack  = 1'b1;
        imem_data = 16'hFFFF;
        tick();
        tick();
        imem_ack = 1'b0;
        checks++;
        if ({we, rs1, rs2, rs3} !== {1'b1, 3'd2, 3'd1, 3'd5}) begin
            errors++;
            $display("FAIL ignore_ack_ir: got we=%0b rs=%0d/%0d/%0d want 1 2/1/5", we, rs1, rs2, rs3);
        end
        tick();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, m_pc}) begin
            errors++;
            $display("FAIL ignore_ack_pc: got req=%0b addr=%0d want 1 %0d", imem_req, imem_addr, m_pc);
        end
    endtask

    task automatic test_wrap;
        do_reset();
        issue(16'h603E, 0, 1'b1);
        wait_fetch();
        checks++;
        if (imem_addr !== 8'd255) begin errors++; $display("FAIL wrap_pc255: got %0d want 255", imem_addr); end
        issue(16'h0250, 0, 1'b1);
        checks++;
        if (pc_out !== 32'd0) begin errors++; $display("FAIL wrap_pc0: got %0d want 0", pc_out); end
        wait_fetch();
    endtask

    task automatic test_halt;
        issue(16'h7000, 0, 1'b1);
        tick();
        checks++;
        if ({halted, imem_req} !== 2'b10) begin
            errors++;
            $display("FAIL halt_enter: got halted=%0b req=%0b want 1 0", halted, imem_req);
        end
        imem_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({halted, imem_req, we, is_branch} !== 4'b1000) begin
                errors++;
                $display("FAIL halt_sticky_%0d: got halt/req/we/br=%b want 1000", i,
                         {halted, imem_req, we, is_branch});
            end
        end
        imem_ack = 1'b0;
        do_reset();
        checks++;
        if ({halted, imem_req, imem_addr} !== {1'b0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL halt_exit: got halted=%0b req=%0b addr=%0d want 0 1 0", halted, imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_exec;
        issue(16'h0250, 0, 1'b0);
        issue_abort();
    endtask

    task automatic issue_abort;
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({imem_req, we} !== 2'b10 || pc_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_exec: got req=%0b we=%0b pc=%0d want 1 0 0", imem_req, we, pc_out);
        end
        reset = 1'b0;
        m_pc  = '0;
        tick();
        tick();
        checks++;
        if ({we, imem_req, imem_addr} !== {1'b0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL reset_exec_after: got we=%0b req=%0b addr=%0d want 0 1 0", we, imem_req, imem_addr);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] ins;
        for (int i = 0; i < 12; i++) begin
            ins = 16'($urandom);
            ins[15:12] = 4'($urandom_range(0, 6));
            wait_fetch();
            issue(ins, $urandom_range(0, 2), 1'b1);
        end
        wait_fetch();
        checks++;
        if (imem_addr !== m_pc) begin
            errors++;
            $display("FAIL b2b_pc: got %0d want %0d", imem_addr, m_pc);
        end
    endtask

`ifdef RETIRE_CNT_EN
    task automatic test_retire;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wait_fetch();
            issue(16'h0250, 0, 1'b1);
        end
        wait_fetch();
        issue(16'h9000, 0, 1'b1);
        wait_fetch();
        checks++;
        if (retired !== 32'd3) begin errors++; $display("FAIL retire_count: got %0d want 3", retired); end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        m_pc      = '0;
        test_reset();
        test_add();
        test_wait();
        test_branch();
        test_ldi_r7();
        test_illegal();
        test_ignore_ack();
        test_wrap();
        test_halt();
        test_reset_exec();
        test_back_to_back();
`ifdef RETIRE_CNT_EN
        test_retire();
`endif
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_writebacks: got %0d outstanding want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
